rotate_stream: RTL and testbench
================================

Name: rotate_stream

Overview:
- Parametrised successor to the fixed 90-degree camera rotator.
- Converts the raster-order camera pixel stream (IN_W pixels per line, IN_H lines) into frame-buffer write addresses for one of four rotations (0/90/180/270), with optional horizontal mirror.
- Sits between the camera pixel assembler and the frame-buffer BRAM write port in the cam_clk_in domain.
- Mode changes are applied only at frame boundaries; out-of-bounds pixels are flagged.

Parameters:
- IN_W, 320: pixels per input line.
- IN_H, 240: lines per input frame.
- PIXEL_W, 16: pixel data width.
- ADDR_W, $clog2(IN_W*IN_H): frame-buffer address width (17 at defaults).
- MODE_RST, 2'd1: active mode after reset (90 degrees).

Ports:
- cam_clk_in  in  1  camera pixel clock.
- rst_in  in  1  synchronous active-high reset.
- valid_pixel_in  in  1  pixel_in valid this cycle.
- pixel_in  in  PIXEL_W  pixel data.
- frame_done_in  in  1  single-cycle pulse; the next valid pixel is (0,0).
- mode_in  in  2  requested rotation: 0=0deg, 1=90deg, 2=180deg, 3=270deg.
- mirror_in  in  1  requested horizontal mirror.
- valid_pixel_out  out  1  write strobe.
- pixel_out  out  PIXEL_W  pixel data aligned with the address.
- pixel_addr_out  out  ADDR_W  frame-buffer write address.
- active_mode_out  out  2  mode in effect for the current frame.
- overflow_out  out  1  sticky: the frame exceeded IN_W*IN_H pixels.

Behaviour:
- Counters:
  - x (0..IN_W-1) and y (0..IN_H-1) track the position of the next input pixel.
  - On each accepted valid pixel, x increments. At x=IN_W-1, x wraps to 0 and y increments.
  - At x=IN_W-1 and y=IN_H-1 the frame is full: the counters hold and the full flag is set.
- Mirror: xm = mirror ? IN_W-1-x : x.
- Address by active mode:
  - 0: y*IN_W + xm.
  - 1: (IN_W-1-xm)*IN_H + y.
  - 2: (IN_H-1-y)*IN_W + (IN_W-1-xm).
  - 3: xm*IN_H + (IN_H-1-y).
- Address arithmetic:
  - Computed incrementally with adders and per-mode step constants; no multipliers in the datapath.
  - Must equal the formula exactly for every pixel. Address is always < IN_W*IN_H.
- Latency: exactly 1 cycle. valid_pixel_out, pixel_out and pixel_addr_out are registered together and describe the same pixel.
- Idle cycles: when valid_pixel_in=0, valid_pixel_out=0 next cycle; pixel_out and pixel_addr_out hold their last values.
- frame_done_in:
  - Clears x, y and the full flag.
  - Latches mode_in/mirror_in into the active registers.
  - Clears overflow_out.
- frame_done_in and valid_pixel_in in the same cycle: the pixel is processed as (0,0) of the new frame, using the newly latched mode. Counters then point at (1,0).
- Mode/mirror changes without frame_done_in: ignored until the next frame_done_in.
- Overflow:
  - A valid pixel arriving while the full flag is set gives valid_pixel_out=0 on the next cycle.
  - overflow_out is set and stays set until frame_done_in or reset.
- Short frame: frame_done_in before IN_W*IN_H pixels simply restarts the frame. No flag is raised.
- Reset (rst_in, any time including mid-frame):
  - x=y=0, full flag=0.
  - valid_pixel_out=0, pixel_out=0, pixel_addr_out=0, overflow_out=0.
  - active mode=MODE_RST, mirror=0.
  - The next valid pixel is (0,0).
- No backpressure: the block accepts one pixel per cycle unconditionally.

Decomposition:
- Package rotate_pkg:
  - rot_mode_t enum: ROT_0, ROT_90, ROT_180, ROT_270.
  - Helper constant functions for per-mode start address, x-step and line-step, given IN_W/IN_H.
- Sub-module rotate_addr_gen: owns x/y counters, full flag and incremental address register.
  - Inputs: advance, restart, mode, mirror.
  - Outputs: addr, full.
- The top level owns the mode latch, output register stage and overflow flag.

Test Plan:
- Mode 1, mirror 0, defaults, after frame_done:
  - pixels 1, 2 -> addr 76560, 76320.
  - pixel 320 -> addr 0.
  - pixel 321 -> addr 76561.
  - last pixel -> addr 239. Each with valid_pixel_out one cycle after input.
- Mode 0 -> addresses 0,1,2,... and last 76799. Mode 2 -> first 76799, last 0.
- Mode 3:
  - pixels 1, 2 -> 239, 479.
  - pixel 321 -> 238.
  - with mirror=1, pixel 1 -> 76799.
- mode_in changed 0->2 mid-frame -> addresses continue mode-0 sequence and active_mode_out stays 0. After frame_done, active_mode_out=2 and first addr 76799.
- Overflow and reset:
  - 76801 valid pixels in one frame -> the 76801st gives valid_pixel_out=0 and overflow_out=1.
  - frame_done clears overflow_out to 0.
  - rst_in mid-frame -> all outputs 0, active_mode_out=1, next pixel addr 76560.
- frame_done_in and valid_pixel_in in the same cycle with mode_in=0 -> that pixel addr 0 and active mode 0. Next pixel addr 1.

Source files
------------

// File: rtl/rotate_pkg.sv
// Shared types and per-mode address-walk constants for the rotating pixel stream.
// Each mode is an affine walk: start address at (0,0), a step per pixel and a step per line wrap.
package rotate_pkg;

    typedef enum logic [1:0] {
        ROT_0   = 2'd0,
        ROT_90  = 2'd1,
        ROT_180 = 2'd2,
        ROT_270 = 2'd3
    } rot_mode_t;

    function automatic int rot_start_addr(rot_mode_t mode, logic mirror, int w, int h);
        case (mode)
            ROT_0:   return mirror ? w - 1 : 0;
            ROT_90:  return mirror ? 0 : (w - 1) * h;
            ROT_180: return mirror ? (h - 1) * w : w * h - 1;
            default: return mirror ? w * h - 1 : h - 1;
        endcase
    endfunction

    function automatic int rot_x_step(rot_mode_t mode, logic mirror, int w, int h);
        case (mode)
            ROT_0:   return mirror ? -1 : 1;
            ROT_90:  return mirror ? h : -h;
            ROT_180: return mirror ? 1 : -1;
            default: return mirror ? -h : h;
        endcase
    endfunction

    function automatic int rot_y_step(rot_mode_t mode, int w);
        case (mode)
            ROT_0:   return w;
            ROT_90:  return 1;
            ROT_180: return -w;
            default: return -1;
        endcase
    endfunction

    // Delta from the last pixel of a line to the first pixel of the next line.
    function automatic int rot_line_step(rot_mode_t mode, logic mirror, int w, int h);
        return rot_y_step(mode, w) - (w - 1) * rot_x_step(mode, mirror, w, h);
    endfunction

endpackage

// File: rtl/rotate_addr_gen.sv
// Tracks the input raster position and walks the frame-buffer address incrementally.
// o_addr/o_full describe the pixel arriving this cycle, already accounting for a restart.
module rotate_addr_gen
    import rotate_pkg::*;
#(
    parameter int unsigned IN_W     = 320,
    parameter int unsigned IN_H     = 240,
    parameter int unsigned ADDR_W   = $clog2(IN_W * IN_H),
    parameter logic [1:0]  MODE_RST = 2'd1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_advance,
    input  logic              i_restart,
    input  rot_mode_t         i_mode,
    input  logic              i_mirror,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_full
);

    localparam int unsigned XW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int unsigned YW = (IN_H > 1) ? $clog2(IN_H) : 1;

    logic [XW-1:0]     r_x, w_x_base, w_x_nxt;
    logic [YW-1:0]     r_y, w_y_base, w_y_nxt;
    logic              r_full, w_full_base, w_full_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_base, w_addr_nxt;
    logic [ADDR_W-1:0] w_start, w_x_step, w_line_step;

    // Negative steps wrap modulo 2^ADDR_W; the true address always lands in range.
    always_comb begin
        w_start     = ADDR_W'(rot_start_addr(i_mode, i_mirror, int'(IN_W), int'(IN_H)));
        w_x_step    = ADDR_W'(rot_x_step(i_mode, i_mirror, int'(IN_W), int'(IN_H)));
        w_line_step = ADDR_W'(rot_line_step(i_mode, i_mirror, int'(IN_W), int'(IN_H)));
    end

    always_comb begin
        w_x_base    = i_restart ? '0 : r_x;
        w_y_base    = i_restart ? '0 : r_y;
        w_full_base = i_restart ? 1'b0 : r_full;
        w_addr_base = i_restart ? w_start : r_addr;

        w_x_nxt    = w_x_base;
        w_y_nxt    = w_y_base;
        w_full_nxt = w_full_base;
        w_addr_nxt = w_addr_base;
        if (i_advance && !w_full_base) begin
            if (w_x_base == XW'(IN_W - 1)) begin
                if (w_y_base == YW'(IN_H - 1)) begin
                    w_full_nxt = 1'b1;
                end else begin
                    w_x_nxt    = '0;
                    w_y_nxt    = w_y_base + YW'(1);
                    w_addr_nxt = w_addr_base + w_line_step;
                end
            end else begin
                w_x_nxt    = w_x_base + XW'(1);
                w_addr_nxt = w_addr_base + w_x_step;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_full <= 1'b0;
            r_addr <= ADDR_W'(rot_start_addr(rot_mode_t'(MODE_RST), 1'b0,
                                             int'(IN_W), int'(IN_H)));
        end else begin
            r_x    <= w_x_nxt;
            r_y    <= w_y_nxt;
            r_full <= w_full_nxt;
            r_addr <= w_addr_nxt;
        end
    end

    assign o_addr = w_addr_base;
    assign o_full = w_full_base;

endmodule

// File: rtl/rotate_stream.sv
// Raster camera stream to rotated/mirrored frame-buffer writes, one cycle of latency.
// Mode and mirror only take effect on frame_done_in; excess pixels raise a sticky overflow.
module rotate_stream
    import rotate_pkg::*;
#(
    parameter int unsigned IN_W     = 320,
    parameter int unsigned IN_H     = 240,
    parameter int unsigned PIXEL_W  = 16,
    parameter int unsigned ADDR_W   = $clog2(IN_W * IN_H),
    parameter logic [1:0]  MODE_RST = 2'd1
) (
    input  logic               cam_clk_in,
    input  logic               rst_in,
    input  logic               valid_pixel_in,
    input  logic [PIXEL_W-1:0] pixel_in,
    input  logic               frame_done_in,
    input  logic [1:0]         mode_in,
    input  logic               mirror_in,
    output logic               valid_pixel_out,
    output logic [PIXEL_W-1:0] pixel_out,
    output logic [ADDR_W-1:0]  pixel_addr_out,
    output logic [1:0]         active_mode_out,
    output logic               overflow_out
);

    rot_mode_t          r_mode;
    logic               r_mirror;
    logic               r_valid;
    logic [PIXEL_W-1:0] r_pixel;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_overflow;

    rot_mode_t          w_mode;
    logic               w_mirror;
    logic [ADDR_W-1:0]  w_addr;
    logic               w_full;
    logic               w_accept;

    // A pixel coinciding with frame_done_in already uses the newly requested mode.
    assign w_mode   = frame_done_in ? rot_mode_t'(mode_in) : r_mode;
    assign w_mirror = frame_done_in ? mirror_in : r_mirror;
    assign w_accept = valid_pixel_in && !w_full;

    rotate_addr_gen #(
        .IN_W     (IN_W),
        .IN_H     (IN_H),
        .ADDR_W   (ADDR_W),
        .MODE_RST (MODE_RST)
    ) u_addr_gen (
        .i_clk     (cam_clk_in),
        .i_rst     (rst_in),
        .i_advance (valid_pixel_in),
        .i_restart (frame_done_in),
        .i_mode    (w_mode),
        .i_mirror  (w_mirror),
        .o_addr    (w_addr),
        .o_full    (w_full)
    );

    always_ff @(posedge cam_clk_in) begin
        if (rst_in) begin
            r_mode     <= rot_mode_t'(MODE_RST);
            r_mirror   <= 1'b0;
            r_valid    <= 1'b0;
            r_pixel    <= '0;
            r_addr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_mode     <= w_mode;
            r_mirror   <= w_mirror;
            r_valid    <= w_accept;
            r_overflow <= (r_overflow && !frame_done_in) || (valid_pixel_in && w_full);
            if (w_accept) begin
                r_pixel <= pixel_in;
                r_addr  <= w_addr;
            end
        end
    end

    assign valid_pixel_out = r_valid;
    assign pixel_out       = r_pixel;
    assign pixel_addr_out  = r_addr;
    assign active_mode_out = r_mode;
    assign overflow_out    = r_overflow;

endmodule

// File: tb/tb_rotate_stream.sv
// Drives one stimulus stream into a default-size and a small rotator; a formula-based
// model pushes expected outputs to a scoreboard that is popped one cycle later.
module tb_rotate_stream;

    localparam int W0 = 320;
    localparam int H0 = 240;
    localparam int SW = 6;
    localparam int SH = 4;
    localparam int PW = 16;
    localparam int AW0 = $clog2(W0 * H0);
    localparam int AW1 = $clog2(SW * SH);

    logic          clk = 1'b0;
    logic          rst, vin, fd, mir;
    logic [1:0]    md;
    logic [PW-1:0] pix;

    logic           v0, v1, o0, o1;
    logic [PW-1:0]  p0, p1;
    logic [AW0-1:0] a0;
    logic [AW1-1:0] a1;
    logic [1:0]     m0, m1;

    always #5 clk = ~clk;

    rotate_stream #(
        .IN_W (W0), .IN_H (H0), .PIXEL_W (PW), .ADDR_W (AW0), .MODE_RST (2'd1)
    ) u_dut (
        .cam_clk_in      (clk),
        .rst_in          (rst),
        .valid_pixel_in  (vin),
        .pixel_in        (pix),
        .frame_done_in   (fd),
        .mode_in         (md),
        .mirror_in       (mir),
        .valid_pixel_out (v0),
        .pixel_out       (p0),
        .pixel_addr_out  (a0),
        .active_mode_out (m0),
        .overflow_out    (o0)
    );

    rotate_stream #(
        .IN_W (SW), .IN_H (SH), .PIXEL_W (PW), .ADDR_W (AW1), .MODE_RST (2'd1)
    ) u_small (
        .cam_clk_in      (clk),
        .rst_in          (rst),
        .valid_pixel_in  (vin),
        .pixel_in        (pix),
        .frame_done_in   (fd),
        .mode_in         (md),
        .mirror_in       (mir),
        .valid_pixel_out (v1),
        .pixel_out       (p1),
        .pixel_addr_out  (a1),
        .active_mode_out (m1),
        .overflow_out    (o1)
    );

    typedef struct {
        int valid;
        int pix;
        int addr;
        int ovf;
        int mode;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int mw[2] = '{W0, SW};
    int mh[2] = '{H0, SH};
    int mx[2], my[2], mfull[2], mmode[2], mmir[2], movf[2], mpix[2], maddr[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_addr(int mode, int mirror, int x, int y, int w, int h);
        int xm;
        xm = mirror != 0 ? w - 1 - x : x;
        case (mode)
            0:       return y * w + xm;
            1:       return (w - 1 - xm) * h + y;
            2:       return (h - 1 - y) * w + (w - 1 - xm);
            default: return xm * h + (h - 1 - y);
        endcase
    endfunction

    task automatic step(input bit v, input bit f, input bit r);
        exp_t e;
        int   ev;
        rst = r;
        vin = v;
        fd  = f;
        pix = PW'($urandom);
        for (int d = 0; d < 2; d++) begin
            ev = 0;
            if (r) begin
                mx[d] = 0; my[d] = 0; mfull[d] = 0; mmode[d] = 1; mmir[d] = 0;
                movf[d] = 0; mpix[d] = 0; maddr[d] = 0;
            end else begin
                if (f) begin
                    mx[d] = 0; my[d] = 0; mfull[d] = 0; movf[d] = 0;
                    mmode[d] = int'(md); mmir[d] = int'(mir);
                end
                if (v) begin
                    if (mfull[d] != 0) begin
                        movf[d] = 1;
                    end else begin
                        ev       = 1;
                        mpix[d]  = int'(pix);
                        maddr[d] = ref_addr(mmode[d], mmir[d], mx[d], my[d], mw[d], mh[d]);
                        if (mx[d] == mw[d] - 1) begin
                            if (my[d] == mh[d] - 1) mfull[d] = 1;
                            else begin mx[d] = 0; my[d]++; end
                        end else begin
                            mx[d]++;
                        end
                    end
                end
            end
            e = '{ev, mpix[d], maddr[d], movf[d], mmode[d]};
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            e = sb_q.pop_front();
            check($sformatf("d%0d_valid", d), d == 0 ? 32'(v0) : 32'(v1), e.valid);
            check($sformatf("d%0d_pixel", d), d == 0 ? 32'(p0) : 32'(p1), e.pix);
            check($sformatf("d%0d_addr", d), d == 0 ? 32'(a0) : 32'(a1), e.addr);
            check($sformatf("d%0d_ovf", d), d == 0 ? 32'(o0) : 32'(o1), e.ovf);
            check($sformatf("d%0d_mode", d), d == 0 ? 32'(m0) : 32'(m1), e.mode);
        end
    endtask

    initial begin
        rst = 1'b1; vin = 1'b0; fd = 1'b0; md = 2'd0; mir = 1'b0; pix = '0;
        step(0, 0, 1);
        step(1, 0, 1);
        check("rst_valid", 32'(v0), 0);
        check("rst_addr", 32'(a0), 0);
        check("rst_mode", 32'(m0), 1);

        // Full frames on the small instance for every mode/mirror, plus one excess pixel.
        for (int m = 0; m < 4; m++) begin
            for (int mi = 0; mi < 2; mi++) begin
                md  = 2'(m);
                mir = 1'(mi);
                step(0, 1, 0);
                for (int k = 1; k <= SW * SH + 1; k++) begin
                    step(1, 0, 0);
                    if (k == SW * SH && m == 0 && mi == 0) check("s_m0_last", 32'(a1), SW * SH - 1);
                    if (k == SW * SH && m == 2 && mi == 0) check("s_m2_last", 32'(a1), 0);
                    if (k == SW * SH + 1) begin
                        check("s_ovf_valid", 32'(v1), 0);
                        check("s_ovf_flag", 32'(o1), 1);
                    end
                end
                step(0, 0, 0);
            end
        end

        // Default-size mode 1 full frame with one overflow pixel.
        md = 2'd1; mir = 1'b0;
        step(0, 1, 0);
        for (int n = 1; n <= W0 * H0 + 1; n++) begin
            step(1, 0, 0);
            case (n)
                1:           check("m1_p1", 32'(a0), 76560);
                2:           check("m1_p2", 32'(a0), 76320);
                320:         check("m1_p320", 32'(a0), 0);
                321:         check("m1_p321", 32'(a0), 76561);
                W0 * H0:     check("m1_last", 32'(a0), 239);
                W0 * H0 + 1: begin
                    check("ovf_valid", 32'(v0), 0);
                    check("ovf_flag", 32'(o0), 1);
                end
                default: ;
            endcase
        end
        step(0, 1, 0);
        check("ovf_clear", 32'(o0), 0);

        // Mode 0, then a mid-frame request for mode 2 that must wait for frame_done.
        md = 2'd0;
        step(0, 1, 0);
        for (int n = 1; n <= 3; n++) begin
            step(1, 0, 0);
            check("m0_seq", 32'(a0), n - 1);
        end
        md = 2'd2;
        for (int n = 4; n <= 6; n++) begin
            step(1, 0, 0);
            check("m0_hold_addr", 32'(a0), n - 1);
            check("m0_hold_mode", 32'(m0), 0);
        end
        step(0, 1, 0);
        check("m2_mode", 32'(m0), 2);
        step(1, 0, 0);
        check("m2_first", 32'(a0), 76799);
        step(1, 0, 0);

        md = 2'd3; mir = 1'b0;
        step(0, 1, 0);
        for (int n = 1; n <= 321; n++) begin
            step(1, 0, 0);
            if (n == 1) check("m3_p1", 32'(a0), 239);
            if (n == 2) check("m3_p2", 32'(a0), 479);
            if (n == 321) check("m3_p321", 32'(a0), 238);
        end
        mir = 1'b1;
        step(0, 1, 0);
        step(1, 0, 0);
        check("m3_mirror_p1", 32'(a0), 76799);

        // Reset mid-frame.
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 1);
        check("mrst_valid", 32'(v0), 0);
        check("mrst_pixel", 32'(p0), 0);
        check("mrst_addr", 32'(a0), 0);
        check("mrst_ovf", 32'(o0), 0);
        check("mrst_mode", 32'(m0), 1);
        step(1, 0, 0);
        check("mrst_next", 32'(a0), 76560);

        // frame_done and a pixel in the same cycle.
        md = 2'd0; mir = 1'b0;
        step(1, 1, 0);
        check("same_valid", 32'(v0), 1);
        check("same_addr", 32'(a0), 0);
        check("same_mode", 32'(m0), 0);
        step(1, 0, 0);
        check("same_next", 32'(a0), 1);
        step(0, 0, 0);
        check("idle_valid", 32'(v0), 0);
        check("idle_hold", 32'(a0), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
